// File: rtl/clk_gen_pkg.sv
`timescale 1ns/1ps
// Shared types and power-on settings for the programmable clock generator.
// The defaults give a 200 kHz output from a 50 MHz system clock.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } gen_state_e;

    localparam int unsigned DEF_HALF_200K = 125;
    localparam int unsigned DEF_PHASE_MID = 62;

endpackage

// File: rtl/clk_gen_prog.sv
`timescale 1ns/1ps
// Programmable glitch-free clock divider with rise/fall strobes and a mid-bit sample strobe.
// Settings change only at half-period boundaries, so clk_out never produces a runt pulse.
module clk_gen_prog
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEF_HALF  = DEF_HALF_200K,
    parameter int unsigned DEF_PHASE = DEF_PHASE_MID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] half_in,
    input  logic [CNT_W-1:0] phase_in,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             sample_stb,
    output logic             running
);

    gen_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic [CNT_W-1:0] act_half_q, act_half_d;
    logic [CNT_W-1:0] act_phase_q, act_phase_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic [CNT_W-1:0] pend_phase_q, pend_phase_d;
    logic             pend_q, pend_d;
    logic             rise_stb_q, rise_stb_d;
    logic             fall_stb_q, fall_stb_d;
    logic             sample_stb_q, sample_stb_d;

    logic             boundary;
    logic             divide;
    logic [CNT_W-1:0] new_half;
    logic [CNT_W-1:0] new_phase;

    function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] h);
        return (h == '0) ? CNT_W'(1) : h;
    endfunction

    // The phase limit is taken against the half-period stored in the same write.
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                      input logic [CNT_W-1:0] h);
        return (p > h - CNT_W'(1)) ? h - CNT_W'(1) : p;
    endfunction

    assign new_half  = clamp_half(half_in);
    assign new_phase = clamp_phase(phase_in, new_half);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        act_half_d   = act_half_q;
        act_phase_d  = act_phase_q;
        pend_half_d  = pend_half_q;
        pend_phase_d = pend_phase_q;
        pend_d       = pend_q;
        divide       = 1'b0;
        boundary     = (state_q != IDLE) && (cnt_q == act_half_q - CNT_W'(1));

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en && !clk_out_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    divide = 1'b1;
                    // Leaving from the high half waits for the falling edge, unless it is due now.
                    if (!en) begin
                        state_d = boundary ? IDLE : STOP;
                    end
                end
            end
            STOP: begin
                divide = 1'b1;
                if (en) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        if (divide) begin
            if (boundary) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // With no output toggling, IDLE is as safe as a boundary for switching settings.
        if (state_q == IDLE || boundary) begin
            if (load) begin
                act_half_d  = new_half;
                act_phase_d = new_phase;
            end else if (pend_q) begin
                act_half_d  = pend_half_q;
                act_phase_d = pend_phase_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_half_d  = new_half;
            pend_phase_d = new_phase;
            pend_d       = 1'b1;
        end

        rise_stb_d   = divide && boundary && !clk_out_q;
        fall_stb_d   = divide && boundary &&  clk_out_q;
        sample_stb_d = (state_d != IDLE) && clk_out_d && (cnt_d == act_phase_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            act_half_q   <= CNT_W'(DEF_HALF);
            act_phase_q  <= CNT_W'(DEF_PHASE);
            pend_half_q  <= '0;
            pend_phase_q <= '0;
            pend_q       <= 1'b0;
            rise_stb_q   <= 1'b0;
            fall_stb_q   <= 1'b0;
            sample_stb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            act_half_q   <= act_half_d;
            act_phase_q  <= act_phase_d;
            pend_half_q  <= pend_half_d;
            pend_phase_q <= pend_phase_d;
            pend_q       <= pend_d;
            rise_stb_q   <= rise_stb_d;
            fall_stb_q   <= fall_stb_d;
            sample_stb_q <= sample_stb_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign rise_stb   = rise_stb_q;
    assign fall_stb   = fall_stb_q;
    assign sample_stb = sample_stb_q;
    assign running    = (state_q != IDLE);

endmodule
